// File: rtl/controller_emulator.sv
// Joystick command player: queued {buttons, hold} commands are replayed onto the six controller
// pins, one frame per movement tick. Optional feature macro CTRL_EMU_MIRROR_EN adds a 'mirror' input.
module controller_emulator #(
    parameter int TICK_MAX   = 714_285,
    parameter int FIFO_DEPTH = 8,
    parameter int HOLD_W     = 8,
    parameter int GAP_FRAMES = 1
) (
    input  logic                          clk,
    input  logic                          rst_l,
    input  logic                          enable,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [5:0]                    cmd_buttons,
    input  logic [HOLD_W-1:0]             cmd_hold,
`ifdef CTRL_EMU_MIRROR_EN
    input  logic                          mirror,
`endif
    output logic                          left_l,
    output logic                          right_l,
    output logic                          up_l,
    output logic                          down_l,
    output logic                          attack,
    output logic                          shield,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_tick
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TICK_MAX + 1);
    localparam int GW = $clog2(GAP_FRAMES + 2);
    localparam int EW = 6 + HOLD_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Left/right swap applied as the command leaves the queue.
    function automatic logic [5:0] swap_lr(input logic [5:0] b, input logic en);
        swap_lr = en ? {b[5:2], b[0], b[1]} : b;
    endfunction

    // Opposing directions cancel, as a real stick cannot press both.
    function automatic logic [5:0] resolve(input logic [5:0] b);
        logic [5:0] r;
        r = b;
        if (b[0] & b[1]) r[1:0] = 2'b00;
        if (b[2] & b[3]) r[3:2] = 2'b00;
        return r;
    endfunction

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tick;

    assign tick = (tcnt_q == TW'(TICK_MAX - 1));

    always_comb begin
        tcnt_d = tick ? '0 : tcnt_q + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_l) tcnt_q <= '0;
        else        tcnt_q <= tcnt_d;
    end

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          full, empty, push, take;
    logic [EW-1:0] head;
    logic [5:0]    head_btn;
    logic [HOLD_W-1:0] head_hold;

    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign push      = cmd_valid & ~full;
    assign head      = mem_q[rptr_q];
    assign head_btn  = head[EW-1:HOLD_W];
    assign head_hold = head[HOLD_W-1:0];

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {cmd_buttons, cmd_hold};
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (take) rptr_q <= rptr_q + AW'(1);
            case ({push, take})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    logic mirror_en;
`ifdef CTRL_EMU_MIRROR_EN
    assign mirror_en = mirror;
`else
    assign mirror_en = 1'b0;
`endif

    logic [5:0] load_btn;
    assign load_btn = resolve(swap_lr(head_btn, mirror_en));

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [5:0]        btn_q, btn_d;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q <= IDLE;
            hold_q  <= '0;
            gap_q   <= '0;
            btn_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            btn_q   <= btn_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        btn_d   = btn_q;
        take    = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            btn_d   = '0;
        end else if (tick) begin
            case (state_q)
                IDLE: begin
                    take = ~empty;
                end
                DRIVE: begin
                    if (hold_q == HOLD_W'(1)) begin
                        if (GAP_FRAMES == 0 && !empty) begin
                            take = 1'b1;
                        end else begin
                            btn_d = '0;
                            if (GAP_FRAMES == 0) begin
                                state_d = IDLE;
                            end else begin
                                state_d = GAP;
                                gap_d   = GW'(GAP_FRAMES);
                            end
                        end
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
                GAP: begin
                    if (gap_q == GW'(1)) begin
                        if (!empty) take = 1'b1;
                        else        state_d = IDLE;
                    end else begin
                        gap_d = gap_q - GW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    btn_d   = '0;
                end
            endcase
        end
        // A zero-length command is consumed but never shown on the pins.
        if (take) begin
            if (head_hold == '0) begin
                state_d = IDLE;
                btn_d   = '0;
            end else begin
                state_d = DRIVE;
                hold_d  = head_hold;
                btn_d   = load_btn;
            end
        end
    end

    assign left_l     = ~btn_q[0];
    assign right_l    = ~btn_q[1];
    assign up_l       = ~btn_q[2];
    assign down_l     = ~btn_q[3];
    assign attack     = btn_q[4];
    assign shield     = btn_q[5];
    assign busy       = (state_q != IDLE);
    assign cmd_ready  = ~full;
    assign fifo_count = count_q;
    assign frame_tick = tick;

endmodule

// File: tb/tb_controller_emulator.sv
// Directed bench for controller_emulator with TICK_MAX=4; a second instance covers GAP_FRAMES=0.
module tb_controller_emulator;

    logic       clk = 1'b0;
    logic       rst_l, enable;
    logic       cmd_valid, g0_valid;
    logic [5:0] cmd_buttons, g0_buttons;
    logic [7:0] cmd_hold, g0_hold;

    logic       cmd_ready, left_l, right_l, up_l, down_l, attack, shield, busy, frame_tick;
    logic [3:0] fifo_count;
    logic       g0_ready, g0_left_l, g0_right_l, g0_up_l, g0_down_l, g0_attack, g0_shield;
    logic       g0_busy, g0_tick;
    logic [3:0] g0_count;

    logic [5:0] pins, g0_pins;
    assign pins    = {shield, attack, down_l, up_l, right_l, left_l};
    assign g0_pins = {g0_shield, g0_attack, g0_down_l, g0_up_l, g0_right_l, g0_left_l};

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    controller_emulator #(.TICK_MAX(4), .FIFO_DEPTH(8), .HOLD_W(8), .GAP_FRAMES(1)) dut (
        .clk(clk), .rst_l(rst_l), .enable(enable),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_buttons(cmd_buttons), .cmd_hold(cmd_hold),
`ifdef CTRL_EMU_MIRROR_EN
        .mirror(1'b0),
`endif
        .left_l(left_l), .right_l(right_l), .up_l(up_l), .down_l(down_l),
        .attack(attack), .shield(shield), .busy(busy),
        .fifo_count(fifo_count), .frame_tick(frame_tick)
    );

    controller_emulator #(.TICK_MAX(4), .FIFO_DEPTH(8), .HOLD_W(8), .GAP_FRAMES(0)) dut_g0 (
        .clk(clk), .rst_l(rst_l), .enable(enable),
        .cmd_valid(g0_valid), .cmd_ready(g0_ready),
        .cmd_buttons(g0_buttons), .cmd_hold(g0_hold),
`ifdef CTRL_EMU_MIRROR_EN
        .mirror(1'b0),
`endif
        .left_l(g0_left_l), .right_l(g0_right_l), .up_l(g0_up_l), .down_l(g0_down_l),
        .attack(g0_attack), .shield(g0_shield), .busy(g0_busy),
        .fifo_count(g0_count), .frame_tick(g0_tick)
    );

    function automatic logic [5:0] pin_exp(input logic [5:0] b);
        return {b[5], b[4], ~b[3], ~b[2], ~b[1], ~b[0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic reset_dut();
        rst_l = 1'b0; enable = 1'b1;
        cmd_valid = 1'b0; cmd_buttons = '0; cmd_hold = '0;
        g0_valid = 1'b0; g0_buttons = '0; g0_hold = '0;
        repeat (3) step();
        rst_l = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        logic exp_t;
        reset_dut();
        checks++; if (pins !== pin_exp(6'b0)) begin failures++; $display("FAIL reset_pins got=%b exp=%b", pins, pin_exp(6'b0)); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (fifo_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
        checks++; if (g0_pins !== pin_exp(6'b0)) begin failures++; $display("FAIL reset_g0_pins got=%b exp=%b", g0_pins, pin_exp(6'b0)); end
        for (int i = 0; i < 8; i++) begin
            step();
            exp_t = ((cyc % 4) == 3);
            checks++; if (frame_tick !== exp_t) begin failures++; $display("FAIL tick_period cyc=%0d got=%b exp=%b", cyc, frame_tick, exp_t); end
        end
    endtask

    task automatic test_single();
        logic [5:0] exp_p;
        logic       exp_b;
        reset_dut();
        cmd_valid = 1'b1; cmd_buttons = 6'b000001; cmd_hold = 8'd2;
        for (int i = 0; i < 18; i++) begin
            step();
            if (cyc == 1) cmd_valid = 1'b0;
            exp_p = (cyc >= 4 && cyc <= 11) ? pin_exp(6'b000001) : pin_exp(6'b0);
            exp_b = (cyc >= 4 && cyc <= 15);
            checks++; if (pins !== exp_p) begin failures++; $display("FAIL single_pins cyc=%0d got=%b exp=%b", cyc, pins, exp_p); end
            checks++; if (busy !== exp_b) begin failures++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_b); end
            if (cyc == 1) begin
                checks++; if (fifo_count !== 4'd1) begin failures++; $display("FAIL single_count1 got=%0d exp=1", fifo_count); end
            end
            if (cyc == 4) begin
                checks++; if (fifo_count !== 4'd0) begin failures++; $display("FAIL single_count0 got=%0d exp=0", fifo_count); end
            end
        end
    endtask

    task automatic test_sequence();
        logic [5:0] exp_p;
        logic       exp_b;
        logic [3:0] exp_c;
        reset_dut();
        cmd_valid = 1'b1; cmd_buttons = 6'b010000; cmd_hold = 8'd3;
        for (int i = 0; i < 30; i++) begin
            step();
            if (cyc == 1) begin cmd_buttons = 6'b000100; cmd_hold = 8'd1; end
            if (cyc == 2) cmd_valid = 1'b0;
            exp_p = (cyc >= 4 && cyc <= 15) ? pin_exp(6'b010000) :
                    (cyc >= 20 && cyc <= 23) ? pin_exp(6'b000100) : pin_exp(6'b0);
            exp_b = (cyc >= 4 && cyc <= 27);
            exp_c = (cyc == 1) ? 4'd1 : (cyc <= 3) ? 4'd2 : (cyc <= 19) ? 4'd1 : 4'd0;
            checks++; if (pins !== exp_p) begin failures++; $display("FAIL seq_pins cyc=%0d got=%b exp=%b", cyc, pins, exp_p); end
            checks++; if (busy !== exp_b) begin failures++; $display("FAIL seq_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_b); end
            checks++; if (fifo_count !== exp_c) begin failures++; $display("FAIL seq_count cyc=%0d got=%0d exp=%0d", cyc, fifo_count, exp_c); end
        end
    endtask

    task automatic test_full();
        logic [3:0] exp_c;
        reset_dut();
        enable = 1'b0; cmd_valid = 1'b1; cmd_hold = 8'd1;
        for (int k = 0; k < 9; k++) begin
            cmd_buttons = (k == 0) ? 6'b001000 : (k == 1) ? 6'b100000 : 6'b010000;
            exp_c = 4'(k);
            checks++; if (cmd_ready !== (k < 8)) begin failures++; $display("FAIL full_ready k=%0d got=%b exp=%b", k, cmd_ready, (k < 8)); end
            checks++; if (fifo_count !== exp_c) begin failures++; $display("FAIL full_fill k=%0d got=%0d exp=%0d", k, fifo_count, exp_c); end
            step();
        end
        cmd_valid = 1'b0;
        checks++; if (fifo_count !== 4'd8) begin failures++; $display("FAIL full_count got=%0d exp=8", fifo_count); end
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL full_ready_hold got=%b exp=0", cmd_ready); end
        checks++; if (busy !== 1'b0 || pins !== pin_exp(6'b0)) begin failures++; $display("FAIL full_idle busy=%b pins=%b exp busy=0 pins=%b", busy, pins, pin_exp(6'b0)); end
        enable = 1'b1;
        while (cyc < 21) begin
            step();
            if (cyc == 19) begin cmd_valid = 1'b1; cmd_buttons = 6'b010000; end
            if (cyc == 20) cmd_valid = 1'b0;
            if (cyc == 11) begin
                checks++; if (fifo_count !== 4'd8) begin failures++; $display("FAIL full_prepop got=%0d exp=8", fifo_count); end
            end
            if (cyc == 12) begin
                checks++; if (fifo_count !== 4'd7) begin failures++; $display("FAIL full_pop got=%0d exp=7", fifo_count); end
                checks++; if (pins !== pin_exp(6'b001000)) begin failures++; $display("FAIL full_first got=%b exp=%b", pins, pin_exp(6'b001000)); end
            end
            if (cyc == 20) begin
                checks++; if (fifo_count !== 4'd7) begin failures++; $display("FAIL full_pushpop got=%0d exp=7", fifo_count); end
                checks++; if (pins !== pin_exp(6'b100000)) begin failures++; $display("FAIL full_second got=%b exp=%b", pins, pin_exp(6'b100000)); end
            end
        end
    endtask

    task automatic test_conflict();
        logic [5:0] exp_p;
        reset_dut();
        cmd_valid = 1'b1; cmd_buttons = 6'b100011; cmd_hold = 8'd1;
        for (int i = 0; i < 18; i++) begin
            step();
            if (cyc == 1) cmd_buttons = 6'b011100;
            if (cyc == 2) cmd_valid = 1'b0;
            exp_p = (cyc >= 4 && cyc <= 7) ? pin_exp(6'b100000) :
                    (cyc >= 12 && cyc <= 15) ? pin_exp(6'b010000) : pin_exp(6'b0);
            checks++; if (pins !== exp_p) begin failures++; $display("FAIL conflict_pins cyc=%0d got=%b exp=%b", cyc, pins, exp_p); end
        end
    endtask

    task automatic test_enable_abort();
        logic [5:0] exp_p;
        logic       exp_b;
        logic [3:0] exp_c;
        reset_dut();
        cmd_valid = 1'b1; cmd_buttons = 6'b000010; cmd_hold = 8'd5;
        for (int i = 0; i < 24; i++) begin
            step();
            if (cyc == 1) begin cmd_buttons = 6'b010000; cmd_hold = 8'd1; end
            if (cyc == 2) cmd_valid = 1'b0;
            if (cyc == 9) enable = 1'b0;
            if (cyc == 12) enable = 1'b1;
            exp_p = (cyc >= 4 && cyc <= 9) ? pin_exp(6'b000010) :
                    (cyc >= 16 && cyc <= 19) ? pin_exp(6'b010000) : pin_exp(6'b0);
            exp_b = (cyc >= 4 && cyc <= 9) || (cyc >= 16 && cyc <= 23);
            exp_c = (cyc == 1) ? 4'd1 : (cyc <= 3) ? 4'd2 : (cyc <= 15) ? 4'd1 : 4'd0;
            checks++; if (pins !== exp_p) begin failures++; $display("FAIL abort_pins cyc=%0d got=%b exp=%b", cyc, pins, exp_p); end
            checks++; if (busy !== exp_b) begin failures++; $display("FAIL abort_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_b); end
            checks++; if (fifo_count !== exp_c) begin failures++; $display("FAIL abort_count cyc=%0d got=%0d exp=%0d", cyc, fifo_count, exp_c); end
        end
    endtask

    task automatic test_drop();
        logic [5:0] exp_p, exp_g;
        logic       exp_b, exp_gb;
        reset_dut();
        cmd_valid = 1'b1; cmd_buttons = 6'b000001; cmd_hold = 8'd1;
        g0_valid  = 1'b1; g0_buttons  = 6'b000001; g0_hold  = 8'd1;
        for (int i = 0; i < 25; i++) begin
            step();
            if (cyc == 1) begin cmd_buttons = 6'b000100; cmd_hold = 8'd0; g0_buttons = 6'b000100; g0_hold = 8'd0; end
            if (cyc == 2) begin cmd_buttons = 6'b010000; cmd_hold = 8'd1; g0_buttons = 6'b010000; g0_hold = 8'd1; end
            if (cyc == 3) begin cmd_valid = 1'b0; g0_valid = 1'b0; end
            exp_p  = (cyc >= 4 && cyc <= 7) ? pin_exp(6'b000001) :
                     (cyc >= 16 && cyc <= 19) ? pin_exp(6'b010000) : pin_exp(6'b0);
            exp_b  = (cyc >= 4 && cyc <= 11) || (cyc >= 16 && cyc <= 23);
            exp_g  = (cyc >= 4 && cyc <= 7) ? pin_exp(6'b000001) :
                     (cyc >= 12 && cyc <= 15) ? pin_exp(6'b010000) : pin_exp(6'b0);
            exp_gb = (cyc >= 4 && cyc <= 7) || (cyc >= 12 && cyc <= 15);
            checks++; if (pins !== exp_p) begin failures++; $display("FAIL drop_pins cyc=%0d got=%b exp=%b", cyc, pins, exp_p); end
            checks++; if (busy !== exp_b) begin failures++; $display("FAIL drop_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_b); end
            checks++; if (g0_pins !== exp_g) begin failures++; $display("FAIL gap0_drop_pins cyc=%0d got=%b exp=%b", cyc, g0_pins, exp_g); end
            checks++; if (g0_busy !== exp_gb) begin failures++; $display("FAIL gap0_drop_busy cyc=%0d got=%b exp=%b", cyc, g0_busy, exp_gb); end
            if (cyc == 8) begin
                checks++; if (g0_count !== 4'd1) begin failures++; $display("FAIL gap0_drop_count got=%0d exp=1", g0_count); end
            end
            if (cyc == 12) begin
                checks++; if (fifo_count !== 4'd1) begin failures++; $display("FAIL drop_count got=%0d exp=1", fifo_count); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_g;
        reset_dut();
        g0_valid = 1'b1; g0_buttons = 6'b000001; g0_hold = 8'd1;
        for (int i = 0; i < 14; i++) begin
            step();
            if (cyc == 1) g0_buttons = 6'b000010;
            if (cyc == 2) g0_valid = 1'b0;
            exp_g = (cyc >= 4 && cyc <= 7) ? pin_exp(6'b000001) :
                    (cyc >= 8 && cyc <= 11) ? pin_exp(6'b000010) : pin_exp(6'b0);
            checks++; if (g0_pins !== exp_g) begin failures++; $display("FAIL b2b_pins cyc=%0d got=%b exp=%b", cyc, g0_pins, exp_g); end
        end
    endtask

    task automatic test_reset_mid();
        logic exp_t;
        reset_dut();
        cmd_valid = 1'b1; cmd_buttons = 6'b000001; cmd_hold = 8'd3;
        while (cyc < 6) begin
            step();
            if (cyc == 1) begin cmd_buttons = 6'b100000; cmd_hold = 8'd1; end
            if (cyc == 2) cmd_valid = 1'b0;
        end
        checks++; if (pins !== pin_exp(6'b000001)) begin failures++; $display("FAIL rmid_pre got=%b exp=%b", pins, pin_exp(6'b000001)); end
        rst_l = 1'b0;
        step();
        rst_l = 1'b1;
        checks++; if (pins !== pin_exp(6'b0)) begin failures++; $display("FAIL rmid_pins got=%b exp=%b", pins, pin_exp(6'b0)); end
        checks++; if (fifo_count !== 4'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", fifo_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        while (cyc < 20) begin
            step();
            exp_t = ((cyc - 7) % 4) == 3;
            checks++; if (pins !== pin_exp(6'b0) || busy !== 1'b0) begin failures++; $display("FAIL rmid_quiet cyc=%0d pins=%b busy=%b exp pins=%b busy=0", cyc, pins, busy, pin_exp(6'b0)); end
            checks++; if (frame_tick !== exp_t) begin failures++; $display("FAIL rmid_tick cyc=%0d got=%b exp=%b", cyc, frame_tick, exp_t); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sequence();
        test_full();
        test_conflict();
        test_enable_abort();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
